rv32_bram_ctrl: RTL and testbench
=================================

# rv32_bram_ctrl

Core-side memory controller that drives one 16-bit simple dual-port ICE40 BRAM from the multicycle core's 32-bit load/store request port. Each aligned 32-bit access becomes two sequential halfword BRAM accesses, little-endian. When byte enables are compiled in, sub-word stores use read-modify-write. Sits between the core's memory stage and the BRAM, acting as the initiator on the BRAM write and read ports.

## Interface

- DEPTH, 256, BRAM depth in 16-bit halfwords; power of two ≥ 4; AW = $clog2(DEPTH).

Ports:
- clk  in  1  sole clock; also drives BRAM wclk and rclk.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  core request valid.
- req_ready  out  1  controller idle and accepting.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- req_be  in  4  byte enables; bit i covers req_wdata[8i+7:8i].
- resp_valid  out  1  one-cycle response strobe; no backpressure.
- resp_rdata  out  32  load data, valid with resp_valid on a load.
- resp_err  out  1  misaligned request, valid with resp_valid.
- bram_wen  out  1  BRAM write enable.
- bram_waddr  out  AW  BRAM write halfword index.
- bram_wdata  out  16  BRAM write data.
- bram_ren  out  1  BRAM read enable.
- bram_raddr  out  AW  BRAM read halfword index.
- bram_rdata  in  16  BRAM registered read data; valid the cycle after bram_ren.

## Operation

- Accept when req_valid && req_ready. req_ready = (state == IDLE). Latch we, addr, wdata, be on accept.
- Halfword indices: lo = {addr[AW:2], 1'b0}, hi = {addr[AW:2], 1'b1}. Address bits above AW are ignored, so addresses alias modulo 2*DEPTH bytes.
- Misalignment: addr[1:0] != 0 goes to RESP with resp_err = 1 and resp_rdata = 0. No BRAM access is made.
- States: IDLE, RD_LO, RD_HI, RD_CAP, WR_H, RMW_RD, RMW_WR, RESP. Register `half` (0 = lo, 1 = hi).
- Load: RD_LO (ren, raddr = lo) → RD_HI (ren, raddr = hi; capture bram_rdata into rdata[15:0]) → RD_CAP (capture bram_rdata into rdata[31:16]) → RESP.
- Store: enter WR_H with half = 0. Let pair = be[2h+1:2h]:
  - pair = 11: wen, waddr = half index, wdata = full halfword.
  - pair = 00: no BRAM access.
  - pair = 01 or 10: go to RMW_RD (ren, raddr = half index), then RMW_WR (wen with merged data: enabled bytes from wdata, others from bram_rdata).
  - After finishing half 0, return to WR_H with half = 1. After half 1, go to RESP.
- RESP: resp_valid = 1 for one cycle, then IDLE. resp_err = 0 for any aligned request.
- BRAM outputs are decoded from state. When an enable is 0, its address and data are 0. wen and ren are never both high for the same index in the same cycle.

## Timing

- Reset values: req_ready = 1; resp_valid, resp_err, bram_wen, bram_ren = 0; resp_rdata, all BRAM addresses and data = 0; state = IDLE; half = 0.
- With accept at cycle T:
  - Load: resp_valid at T+4.
  - Misaligned request: resp_valid at T+2.
  - Store: resp_valid at T+1+2 (two halves) +1 extra cycle for each RMW half. be = 1111 gives T+3; be = 0001 gives T+4; be = 0101 gives T+5.
- Back-to-back: after RESP, the next request is accepted at the earliest in the following IDLE cycle.
- resp_rdata holds its value until the next load response or reset.
- Reset mid-operation: asserting rst_n returns the controller to IDLE immediately and drops all strobes. A store interrupted after its lo half leaves that half written. This is accepted behaviour.

## Configuration

- RV32_BRAM_CTRL_BYTE_EN defined: behaviour as described above, including RMW_RD/RMW_WR.
- Not defined:
  - req_be is ignored and every store is treated as be = 4'b1111.
  - RMW_RD and RMW_WR are not built.
  - Store latency is fixed at T+3.

## Test plan

- Reset with req_valid = 0 → req_ready = 1 and all outputs 0.
- Store addr 0x10, wdata 0xDEADBEEF, be 1111 → wen at T+1 (idx 8, data 0xBEEF) and T+2 (idx 9, data 0xDEAD); resp_valid at T+3. Then load 0x10 → resp_rdata 0xDEADBEEF at T+4.
- With RV32_BRAM_CTRL_BYTE_EN, after the previous store: store 0x10, wdata 0x000000AA, be 0001 → ren idx 8, then wen idx 8 data 0xBEAA; resp_valid at T+4. Load → 0xDEADBEAA.
- Load addr 0x13 → resp_valid = 1 and resp_err = 1 at T+2; bram_wen and bram_ren never assert.
- Store be 0000 → no wen; resp_valid at T+3; memory unchanged.
- Drop rst_n during RD_HI → same cycle: req_ready = 1 and ren = 0; no resp_valid for that request afterward.

Source files
------------

// File: rtl/rv32_bram_ctrl.sv
// rv32_bram_ctrl: bridges the core's 32-bit load/store port onto one 16-bit
// simple dual-port ICE40 BRAM. Each aligned word access becomes two
// halfword accesses, low half first (little-endian).
// Optional feature macro: RV32_BRAM_CTRL_BYTE_EN enables byte enables, with
// sub-halfword stores done as read-modify-write. Without it every store
// writes all four bytes.
module rv32_bram_ctrl #(
  parameter  int DEPTH = 256,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [31:0]   req_addr,
  input  logic [31:0]   req_wdata,
  input  logic [3:0]    req_be,
  output logic          resp_valid,
  output logic [31:0]   resp_rdata,
  output logic          resp_err,
  output logic          bram_wen,
  output logic [AW-1:0] bram_waddr,
  output logic [15:0]   bram_wdata,
  output logic          bram_ren,
  output logic [AW-1:0] bram_raddr,
  input  logic [15:0]   bram_rdata
);

  typedef enum logic [2:0] {
    IDLE, RD_LO, RD_HI, RD_CAP, WR_H, RESP
`ifdef RV32_BRAM_CTRL_BYTE_EN
    , RMW_RD, RMW_WR
`endif
  } state_t;

  state_t          state_q, state_d;
  logic            half_q, half_d;
  logic            err_q;
  logic [AW-2:0]   word_q;      // word index: addr[AW:2]; higher bits alias
  logic [31:0]     wdata_q;
  logic [3:0]      be_q;
  logic [15:0]     lo_q;        // low load halfword, held until the high one arrives
  logic [31:0]     rdata_q;

  logic            accept;
  logic            misaligned;
  logic [3:0]      req_be_eff;
  logic [AW-1:0]   half_idx;
  logic [15:0]     wr_half;
  logic [1:0]      pair;

  assign accept     = req_valid && (state_q == IDLE);
  assign misaligned = (req_addr[1:0] != 2'b00);

`ifdef RV32_BRAM_CTRL_BYTE_EN
  assign req_be_eff = req_be;
`else
  assign req_be_eff = 4'b1111;
`endif

  // Address bits above AW only alias; req_be is unused without byte enables.
  logic unused_ok;
  assign unused_ok = ^{req_addr[31:AW+1], req_be};

  assign half_idx = {word_q, half_q};
  assign wr_half  = half_q ? wdata_q[31:16] : wdata_q[15:0];
  assign pair     = half_q ? be_q[3:2] : be_q[1:0];

  // A partial halfword is sent straight into its read cycle, so each RMW
  // half costs only one cycle more than a plain halfword write.
  function automatic state_t store_entry(input logic [1:0] p);
`ifdef RV32_BRAM_CTRL_BYTE_EN
    return (p == 2'b01 || p == 2'b10) ? RMW_RD : WR_H;
`else
    return (p == 2'b11) ? WR_H : WR_H;
`endif
  endfunction

  // Next-state logic and state-decoded BRAM/handshake outputs.
  always_comb begin
    // NOTE: every output of this block gets a default first so that no path
    // through the case statement can leave one unassigned and infer a latch.
    state_d    = state_q;
    half_d     = half_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    bram_wen   = 1'b0;
    bram_waddr = '0;
    bram_wdata = '0;
    bram_ren   = 1'b0;
    bram_raddr = '0;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          half_d = 1'b0;
          // Misaligned requests spend one silent WR_H cycle before RESP.
          if (misaligned)   state_d = WR_H;
          else if (!req_we) state_d = RD_LO;
          else              state_d = store_entry(req_be_eff[1:0]);
        end
      end
      RD_LO: begin
        bram_ren   = 1'b1;
        bram_raddr = {word_q, 1'b0};
        state_d    = RD_HI;
      end
      RD_HI: begin
        bram_ren   = 1'b1;
        bram_raddr = {word_q, 1'b1};
        state_d    = RD_CAP;
      end
      RD_CAP: state_d = RESP;
      WR_H: begin
        if (!err_q && pair == 2'b11) begin
          bram_wen   = 1'b1;
          bram_waddr = half_idx;
          bram_wdata = wr_half;
        end
        if (err_q || half_q) begin
          state_d = RESP;
        end else begin
          half_d  = 1'b1;
          state_d = store_entry(be_q[3:2]);
        end
      end
`ifdef RV32_BRAM_CTRL_BYTE_EN
      RMW_RD: begin
        bram_ren   = 1'b1;
        bram_raddr = half_idx;
        state_d    = RMW_WR;
      end
      RMW_WR: begin
        bram_wen   = 1'b1;
        bram_waddr = half_idx;
        bram_wdata = {pair[1] ? wr_half[15:8] : bram_rdata[15:8],
                      pair[0] ? wr_half[7:0]  : bram_rdata[7:0]};
        if (half_q) begin
          state_d = RESP;
        end else begin
          half_d  = 1'b1;
          state_d = store_entry(be_q[3:2]);
        end
      end
`endif
      RESP: begin
        resp_valid = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign resp_err   = (state_q == RESP) && err_q;
  assign resp_rdata = rdata_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: registered state is written with <= only, so every flop samples
    // the pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q <= IDLE;
      half_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      half_q  <= half_d;
    end
  end

  // Request latch on accept and load-data capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q   <= 1'b0;
      word_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      lo_q    <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        err_q   <= misaligned;
        word_q  <= req_addr[AW:2];
        wdata_q <= req_wdata;
        be_q    <= req_be_eff;
        if (misaligned) rdata_q <= '0;
      end
      if (state_q == RD_HI)  lo_q    <= bram_rdata;
      if (state_q == RD_CAP) rdata_q <= {bram_rdata, lo_q};
    end
  end

endmodule

// File: tb/tb_rv32_bram_ctrl.sv
// Directed testbench for rv32_bram_ctrl with a behavioural 16-bit BRAM.
// Expectations follow RV32_BRAM_CTRL_BYTE_EN when it is defined.
module tb_rv32_bram_ctrl;
  localparam int DEPTH = 256;
  localparam int AW    = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [31:0]   req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic [3:0]    req_be = '0;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          resp_err;
  logic          bram_wen;
  logic [AW-1:0] bram_waddr;
  logic [15:0]   bram_wdata;
  logic          bram_ren;
  logic [AW-1:0] bram_raddr;
  logic [15:0]   bram_rdata = '0;

  always #5 clk = ~clk;

  rv32_bram_ctrl #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .bram_wen(bram_wen), .bram_waddr(bram_waddr), .bram_wdata(bram_wdata),
    .bram_ren(bram_ren), .bram_raddr(bram_raddr), .bram_rdata(bram_rdata)
  );

  // Behavioural BRAM: synchronous write, registered read.
  logic [15:0] mem [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) mem[i] = '0;
  always @(posedge clk) begin
    if (bram_wen) mem[bram_waddr] <= bram_wdata;
    if (bram_ren) bram_rdata <= mem[bram_raddr];
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  typedef struct {
    int            cyc;
    logic          wen;
    logic          ren;
    logic [AW-1:0] addr;
    logic [15:0]   data;
  } op_t;

  op_t         ops[$];
  int          lat;
  logic [31:0] rsp_data;
  logic        rsp_err;

  // Issue one request, then log BRAM activity per cycle until the response.
  task automatic run_req(input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be);
    ops.delete();
    lat = -1;
    rsp_data = 'x;
    rsp_err  = 1'bx;
    @(negedge clk);
    check("ready_idle", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    @(posedge clk);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = 1'b0;
      if (bram_wen)
        ops.push_back('{cyc: k, wen: 1'b1, ren: 1'b0, addr: bram_waddr, data: bram_wdata});
      if (bram_ren)
        ops.push_back('{cyc: k, wen: 1'b0, ren: 1'b1, addr: bram_raddr, data: 16'h0});
      if (resp_valid) begin
        lat      = k;
        rsp_data = resp_rdata;
        rsp_err  = resp_err;
        break;
      end
    end
  endtask

  // Compare logged BRAM op i against {cycle, wen, ren, addr, data}.
  task automatic check_op(input string tag, input int i, input int cyc, input logic wen,
                          input logic [AW-1:0] addr, input logic [15:0] data);
    if (i < ops.size())
      check(tag, {ops[i].cyc[5:0], ops[i].wen, ops[i].ren, ops[i].addr, ops[i].data},
                 {cyc[5:0], wen, ~wen, addr, data});
    else
      check({tag, "_missing"}, ops.size(), i + 1);
  endtask

  task automatic do_load(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    run_req(1'b0, addr, 32'h0, 4'h0);
    check({tag, "_lat"},  lat, 4);
    check({tag, "_data"}, rsp_data, exp);
    check({tag, "_err"},  {31'b0, rsp_err}, 32'd0);
  endtask

  task automatic do_store(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input int exp_lat, input int exp_ops);
    run_req(1'b1, addr, wdata, be);
    check({tag, "_lat"},  lat, exp_lat);
    check({tag, "_nops"}, ops.size(), exp_ops);
    check({tag, "_err"},  {31'b0, rsp_err}, 32'd0);
  endtask

  logic seen;

  initial begin
    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_ready", {31'b0, req_ready}, 32'd1);
    check("rst_strobes", {28'b0, resp_valid, resp_err, bram_wen, bram_ren}, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_addrs", {bram_waddr, bram_raddr, bram_wdata}, 32'd0);
    rst_n = 1'b1;

    // Full-word store then load.
    do_store("st_full", 32'h10, 32'hDEADBEEF, 4'b1111, 3, 2);
    check_op("st_full_op0", 0, 1, 1'b1, 8'd8, 16'hBEEF);
    check_op("st_full_op1", 1, 2, 1'b1, 8'd9, 16'hDEAD);
    do_load("ld_full", 32'h10, 32'hDEADBEEF);
    check_op("ld_full_op0", 0, 1, 1'b0, 8'd8, 16'h0);
    check_op("ld_full_op1", 1, 2, 1'b0, 8'd9, 16'h0);

`ifdef RV32_BRAM_CTRL_BYTE_EN
    // Single-byte RMW on the low half.
    do_store("st_b0", 32'h10, 32'h000000AA, 4'b0001, 4, 2);
    check_op("st_b0_op0", 0, 1, 1'b0, 8'd8, 16'h0);
    check_op("st_b0_op1", 1, 2, 1'b1, 8'd8, 16'hBEAA);
    do_load("ld_b0", 32'h10, 32'hDEADBEAA);
    // RMW on both halves.
    do_store("st_b02", 32'h10, 32'h00CC00DD, 4'b0101, 5, 4);
    check_op("st_b02_op1", 1, 2, 1'b1, 8'd8, 16'hBEDD);
    check_op("st_b02_op2", 2, 3, 1'b0, 8'd9, 16'h0);
    check_op("st_b02_op3", 3, 4, 1'b1, 8'd9, 16'hDECC);
    do_load("ld_b02", 32'h10, 32'hDECCBEDD);
    // No byte enabled: no BRAM write, memory unchanged.
    do_store("st_none", 32'h10, 32'h12345678, 4'b0000, 3, 0);
    do_load("ld_none", 32'h10, 32'hDECCBEDD);
`else
    // Byte enables ignored: every store writes the full word.
    do_store("st_b0", 32'h10, 32'h000000AA, 4'b0001, 3, 2);
    check_op("st_b0_op0", 0, 1, 1'b1, 8'd8, 16'h00AA);
    do_load("ld_b0", 32'h10, 32'h000000AA);
    do_store("st_none", 32'h10, 32'h12345678, 4'b0000, 3, 2);
    do_load("ld_none", 32'h10, 32'h12345678);
`endif

    // Misaligned load and store: error response, no BRAM access.
    run_req(1'b0, 32'h13, 32'h0, 4'h0);
    check("mis_ld_lat", lat, 2);
    check("mis_ld_err", {31'b0, rsp_err}, 32'd1);
    check("mis_ld_data", rsp_data, 32'd0);
    check("mis_ld_nops", ops.size(), 0);
    run_req(1'b1, 32'h22, 32'hFFFFFFFF, 4'b1111);
    check("mis_st_lat", lat, 2);
    check("mis_st_err", {31'b0, rsp_err}, 32'd1);
    check("mis_st_nops", ops.size(), 0);

    // Aliasing modulo 2*DEPTH bytes, and the topmost word.
    do_store("st_alias", 32'h210, 32'hCAFEF00D, 4'b1111, 3, 2);
    check_op("st_alias_op0", 0, 1, 1'b1, 8'd8, 16'hF00D);
    do_load("ld_alias", 32'h10, 32'hCAFEF00D);
    do_store("st_top", 32'h3FC, 32'h0BADF00D, 4'b1111, 3, 2);
    check_op("st_top_op1", 1, 2, 1'b1, 8'd255, 16'h0BAD);
    do_load("ld_top", 32'h1FC, 32'h0BADF00D);

    // Reset while in RD_HI.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_be = 4'h0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("rdhi_ren", {bram_ren, bram_raddr}, {1'b1, 8'd9});
    #1 rst_n = 1'b0;
    #1;
    check("midrst_ready", {31'b0, req_ready}, 32'd1);
    check("midrst_strobes", {29'b0, bram_ren, bram_wen, resp_valid}, 32'd0);
    check("midrst_rdata", resp_rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (resp_valid) seen = 1'b1;
    end
    check("midrst_no_resp", {31'b0, seen}, 32'd0);
    do_load("ld_after_rst", 32'h10, 32'hCAFEF00D);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
